mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one aligned 32-bit memory port between NUM_REQ requesters (per-core imem/dmem clients in the multi-core build).
- Round-robin arbitration; one transaction in flight at a time.
- Valid/ready request handshake upstream and downstream; variable-latency response downstream.
- Routes the read data/ack back to the granted requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_req_valid  input  NUM_REQ  per-requester request valid.
- o_req_ready  output  NUM_REQ  request accepted this cycle (one-hot or zero).
- i_req_addr  input  32*NUM_REQ  word-aligned address; requester k at [32k+31:32k].
- i_req_wen  input  NUM_REQ  1 = write, 0 = read.
- i_req_wdata  input  32*NUM_REQ  write data.
- i_req_mask  input  4*NUM_REQ  byte-lane mask.
- o_rsp_valid  output  NUM_REQ  response pulse to the owning requester (one-hot or zero).
- o_rsp_rdata  output  32  read data, shared bus; valid only with o_rsp_valid.
- o_rsp_err  output  1  error flag qualifying o_rsp_valid.
- o_mem_valid  output  1  downstream request valid.
- i_mem_ready  input  1  downstream accepts request.
- o_mem_addr  output  32  downstream address.
- o_mem_wen  output  1  downstream write.
- o_mem_ren  output  1  downstream read; equals o_mem_valid & ~o_mem_wen.
- o_mem_wdata  output  32  downstream write data.
- o_mem_mask  output  4  downstream mask.
- i_mem_rsp_valid  input  1  downstream response (read data or write ack).
- i_mem_rdata  input  32  downstream read data.
- o_busy  output  1  transaction in flight.

Behaviour:
- Reset (async assert, sync release): state IDLE; rr_ptr = 0; all outputs 0.
- States:
  - IDLE: if any i_req_valid, select the first valid requester starting at rr_ptr, wrapping modulo NUM_REQ. Pulse o_req_ready[g] for 1 cycle, latch addr/wen/wdata/mask/g into holding regs, go to ISSUE. Otherwise stay.
  - ISSUE: o_mem_valid = 1, driven from holding regs, stable until i_mem_ready. When i_mem_valid & i_mem_ready, go to WAIT.
  - WAIT: o_mem_valid = 0. On i_mem_rsp_valid: o_rsp_valid[g] = 1 for that cycle, o_rsp_rdata = i_mem_rdata (registered output, 1 cycle later than i_mem_rsp_valid), o_rsp_err = 0. Set rr_ptr = (g+1) mod NUM_REQ and go to IDLE.
- Response latency: o_rsp_valid asserts the cycle after i_mem_rsp_valid.
- Back-to-back: a new grant may occur in the IDLE cycle following the response cycle.
- Minimum turnaround: 4 cycles (grant, issue accepted, rsp, rsp out).
- Upstream: requesters hold i_req_valid and payload until o_req_ready; payload is sampled only on the grant cycle.
- i_mem_rsp_valid outside WAIT is ignored; no response is generated.
- i_mem_ready and i_mem_rsp_valid in the same ISSUE cycle: the response is ignored. The downstream must respond at least 1 cycle after accept.
- o_busy = (state != IDLE).
- o_mem_wen and o_mem_ren are never both 1.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 transactions.
- Reset mid-transaction aborts it; no response pulse is issued.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - 8-bit-or-wider counter clears on entering WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without i_mem_rsp_valid: o_rsp_valid[g] = 1 with o_rsp_err = 1 and o_rsp_rdata = 0, rr_ptr advances, state goes to IDLE.
  - A late i_mem_rsp_valid is ignored.
- Undefined: no counter; WAIT is held indefinitely; o_rsp_err is tied 0.

Test Plan:
- Single read: req0 valid, addr 0x1000, i_mem_ready=1, rsp 2 cycles later with 0xDEADBEEF -> o_req_ready=001 once; o_mem_ren=1 with addr 0x1000; o_rsp_valid=001 with rdata 0xDEADBEEF; o_rsp_err=0.
- Round-robin: all 3 valid continuously from reset -> grant order 0,1,2,0,1,2; no requester granted twice before the others.
- Write with backpressure: req2 wen=1, wdata 0x11223344, mask 0b1100; i_mem_ready low 5 cycles -> o_mem_* held stable for all 6 ISSUE cycles; o_mem_wen=1, o_mem_ren=0; ack gives o_rsp_valid=100.
- Reset mid-WAIT: assert i_rst_n=0 asynchronously during WAIT -> all outputs 0 immediately; no o_rsp_valid after release; next grant goes to req0.
- Spurious response: i_mem_rsp_valid while IDLE -> no o_rsp_valid; state stays IDLE.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): req1 read, no response -> after 8 WAIT cycles o_rsp_valid=010, o_rsp_err=1, rdata 0; next grant starts from req2.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one aligned 32-bit memory port between NUM_REQ requesters.
// Define MEM_ARB_TIMEOUT_EN to add a response watchdog that answers with o_rsp_err after TIMEOUT_CYCLES.
module mem_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NUM_REQ-1:0]    i_req_valid,
   output logic [NUM_REQ-1:0]    o_req_ready,
   input  logic [32*NUM_REQ-1:0] i_req_addr,
   input  logic [NUM_REQ-1:0]    i_req_wen,
   input  logic [32*NUM_REQ-1:0] i_req_wdata,
   input  logic [4*NUM_REQ-1:0]  i_req_mask,
   output logic [NUM_REQ-1:0]    o_rsp_valid,
   output logic [31:0]           o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic                  o_mem_valid,
   input  logic                  i_mem_ready,
   output logic [31:0]           o_mem_addr,
   output logic                  o_mem_wen,
   output logic                  o_mem_ren,
   output logic [31:0]           o_mem_wdata,
   output logic [3:0]            o_mem_mask,
   input  logic                  i_mem_rsp_valid,
   input  logic [31:0]           i_mem_rdata,
   output logic                  o_busy,
   output logic [1:0]            o_dbg_state
);
   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // the sender holds valid and payload stable until then, and ready never waits on a future cycle.
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   gnt_q;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   cand;
   int                 cand_sum;
   logic               gnt_found;
   logic [31:0]        sel_addr;
   logic [31:0]        sel_wdata;
   logic               sel_wen;
   logic [3:0]         sel_mask;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic               wen_q;
   logic [3:0]         mask_q;
   logic               mem_valid_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [31:0]        rsp_rdata_q;
   logic               rsp_err_q;
   logic [IDX_W-1:0]   next_ptr;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0]   wait_cnt;
`endif

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand_sum  = 0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_sum = int'(rr_ptr) + i;
         if (cand_sum >= NUM_REQ) cand_sum = cand_sum - NUM_REQ;
         cand = IDX_W'(cand_sum);
         if (!gnt_found && i_req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wen   = 1'b0;
      sel_mask  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_idx == IDX_W'(k)) begin
            sel_addr  = i_req_addr[32*k +: 32];
            sel_wdata = i_req_wdata[32*k +: 32];
            sel_wen   = i_req_wen[k];
            sel_mask  = i_req_mask[4*k +: 4];
         end
      end
   end

   assign next_ptr = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         gnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wen_q       <= 1'b0;
         mask_q      <= '0;
         mem_valid_q <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         wait_cnt    <= '0;
`endif
      end else begin
         rsp_valid_q <= '0;
         case (state)
            IDLE: begin
               if (gnt_found) begin
                  gnt_q       <= gnt_idx;
                  addr_q      <= sel_addr;
                  wdata_q     <= sel_wdata;
                  wen_q       <= sel_wen;
                  mask_q      <= sel_mask;
                  mem_valid_q <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               // A response arriving in the accept cycle itself is dropped.
               if (i_mem_ready) begin
                  mem_valid_q <= 1'b0;
                  state       <= WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                  wait_cnt    <= '0;
`endif
               end
            end
            WAIT: begin
               if (i_mem_rsp_valid) begin
                  rsp_valid_q <= NUM_REQ'(1) << gnt_q;
                  rsp_rdata_q <= i_mem_rdata;
                  rsp_err_q   <= 1'b0;
                  rr_ptr      <= next_ptr;
                  state       <= IDLE;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  rsp_valid_q <= NUM_REQ'(1) << gnt_q;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  rr_ptr      <= next_ptr;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Ready is gated by reset so nothing is granted while the arbiter is held in reset.
   assign o_req_ready = (state == IDLE && gnt_found && i_rst_n) ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign o_mem_valid = mem_valid_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_mem_mask  = mask_q;
   assign o_mem_wen   = mem_valid_q & wen_q;
   assign o_mem_ren   = mem_valid_q & ~wen_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_busy      = (state != IDLE);
   assign o_dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions against a round-robin reference model.
// The watchdog scenario is compiled only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;
   localparam int N   = 3;
   localparam int TMO = 8;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b1;
   logic [N-1:0]      i_req_valid = '0;
   logic [N-1:0]      o_req_ready;
   logic [32*N-1:0]   i_req_addr = '0;
   logic [N-1:0]      i_req_wen = '0;
   logic [32*N-1:0]   i_req_wdata = '0;
   logic [4*N-1:0]    i_req_mask = '0;
   logic [N-1:0]      o_rsp_valid;
   logic [31:0]       o_rsp_rdata;
   logic              o_rsp_err;
   logic              o_mem_valid;
   logic              i_mem_ready = 1'b0;
   logic [31:0]       o_mem_addr;
   logic              o_mem_wen;
   logic              o_mem_ren;
   logic [31:0]       o_mem_wdata;
   logic [3:0]        o_mem_mask;
   logic              i_mem_rsp_valid = 1'b0;
   logic [31:0]       i_mem_rdata = '0;
   logic              o_busy;
   logic [1:0]        o_dbg_state;

   mem_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_addr(i_req_addr), .i_req_wen(i_req_wen),
      .i_req_wdata(i_req_wdata), .i_req_mask(i_req_mask),
      .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
      .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
      .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren),
      .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
      .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rdata(i_mem_rdata),
      .o_busy(o_busy), .o_dbg_state(o_dbg_state)
   );

   // Clock / reset
   always #5 i_clk = ~i_clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: requester payload table, round-robin pointer, expected response data
   logic [31:0] addr_a [N];
   logic        wen_a  [N];
   logic [31:0] wdata_a[N];
   logic [3:0]  mask_a [N];
   int          rr = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_addr, exp_wdata;
   logic        exp_wen;
   logic [3:0]  exp_mask;

   function automatic int model_grant(logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(int g);
      logic [N-1:0] r;
      r = '0;
      if (g >= 0) r = N'(1) << g;
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Driver tasks
   task automatic apply();
      for (int k = 0; k < N; k++) begin
         i_req_addr[32*k +: 32]  = addr_a[k];
         i_req_wen[k]            = wen_a[k];
         i_req_wdata[32*k +: 32] = wdata_a[k];
         i_req_mask[4*k +: 4]    = mask_a[k];
      end
   endtask

   task automatic rand_payload(int k);
      addr_a[k]  = $urandom & 32'hFFFF_FFFC;
      wen_a[k]   = 1'($urandom_range(0, 1));
      wdata_a[k] = $urandom;
      mask_a[k]  = 4'($urandom_range(0, 15));
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_req_ready"}, 32'(o_req_ready), 0);
      chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 0);
      chk({tag, "_rsp_rdata"}, o_rsp_rdata, 0);
      chk({tag, "_rsp_err"},   32'(o_rsp_err), 0);
      chk({tag, "_mem_valid"}, 32'(o_mem_valid), 0);
      chk({tag, "_mem_addr"},  o_mem_addr, 0);
      chk({tag, "_mem_wen"},   32'(o_mem_wen), 0);
      chk({tag, "_mem_ren"},   32'(o_mem_ren), 0);
      chk({tag, "_mem_wdata"}, o_mem_wdata, 0);
      chk({tag, "_mem_mask"},  32'(o_mem_mask), 0);
      chk({tag, "_busy"},      32'(o_busy), 0);
   endtask

   task automatic do_reset();
      i_req_valid = '0;
      i_mem_ready = 1'b0;
      i_mem_rsp_valid = 1'b0;
      i_rst_n = 1'b0;
      #1;
      check_zero("reset");
      @(posedge i_clk);
      step();
      i_rst_n = 1'b1;
      rr = 0;
      exp_q.delete();
   endtask

   // Request phase: one IDLE cycle with valid set v; the winner then moves to a new payload.
   task automatic grant_phase(logic [N-1:0] v, output int g);
      i_req_valid = v;
      apply();
      #1;
      g = model_grant(v);
      chk("req_ready", 32'(o_req_ready), 32'(onehot(g)));
      exp_addr  = addr_a[g];
      exp_wen   = wen_a[g];
      exp_wdata = wdata_a[g];
      exp_mask  = mask_a[g];
      step();
      i_req_valid[g] = 1'b0;
      rand_payload(g);
      apply();
   endtask

   task automatic issue_phase(int ready_delay, bit rsp_in_accept);
      for (int d = 0; d <= ready_delay; d++) begin
         i_mem_ready     = (d == ready_delay);
         i_mem_rsp_valid = (d == ready_delay) && rsp_in_accept;
         i_mem_rdata     = $urandom;
         #1;
         chk("issue_valid", 32'(o_mem_valid), 1);
         chk("issue_addr",  o_mem_addr, exp_addr);
         chk("issue_wen",   32'(o_mem_wen), 32'(exp_wen));
         chk("issue_ren",   32'(o_mem_ren), 32'(!exp_wen));
         chk("issue_wdata", o_mem_wdata, exp_wdata);
         chk("issue_mask",  32'(o_mem_mask), 32'(exp_mask));
         chk("issue_ready0", 32'(o_req_ready), 0);
         chk("issue_busy",  32'(o_busy), 1);
         step();
      end
      i_mem_ready     = 1'b0;
      i_mem_rsp_valid = 1'b0;
   endtask

   task automatic wait_phase(int g, int rsp_delay, logic [31:0] data);
      exp_q.push_back(data);
      for (int d = 0; d <= rsp_delay; d++) begin
         i_mem_rsp_valid = (d == rsp_delay);
         i_mem_rdata     = (d == rsp_delay) ? data : $urandom;
         #1;
         chk("wait_mem_valid", 32'(o_mem_valid), 0);
         chk("wait_rsp_valid", 32'(o_rsp_valid), 0);
         chk("wait_ready0",    32'(o_req_ready), 0);
         chk("wait_busy",      32'(o_busy), 1);
         step();
      end
      i_mem_rsp_valid = 1'b0;
      #1;
      chk("rsp_valid", 32'(o_rsp_valid), 32'(onehot(g)));
      chk("rsp_rdata", o_rsp_rdata, exp_q.pop_front());
      chk("rsp_err",   32'(o_rsp_err), 0);
      chk("rsp_busy",  32'(o_busy), 0);
      rr = (g + 1) % N;
   endtask

   task automatic run_txn(logic [N-1:0] v, int rdly, int sdly, bit rsp_in_accept, logic [31:0] data);
      int g;
      grant_phase(v, g);
      issue_phase(rdly, rsp_in_accept);
      wait_phase(g, sdly, data);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "time limit");
   end

   initial begin
      int g;
      for (int k = 0; k < N; k++) begin
         addr_a[k] = '0; wen_a[k] = 1'b0; wdata_a[k] = '0; mask_a[k] = '0;
      end
      #1;
      do_reset();

      // Single read from requester 0
      addr_a[0] = 32'h0000_1000; wen_a[0] = 1'b0; mask_a[0] = 4'hF;
      run_txn(3'b001, 0, 1, 1'b0, 32'hDEAD_BEEF);

      // Round robin with every requester continuously valid
      do_reset();
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < N; k++) rand_payload(k);
         run_txn(3'b111, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, $urandom);
      end

      // Write with 5 cycles of downstream backpressure
      addr_a[2] = 32'h0000_2040; wen_a[2] = 1'b1; wdata_a[2] = 32'h1122_3344; mask_a[2] = 4'b1100;
      run_txn(3'b100, 5, 2, 1'b0, 32'hA5A5_0001);

      // Spurious downstream responses while idle
      i_req_valid = '0;
      i_mem_rsp_valid = 1'b1;
      i_mem_rdata = 32'hBAD0_BAD0;
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         chk("spur_rsp_valid", 32'(o_rsp_valid), 0);
         chk("spur_busy", 32'(o_busy), 0);
      end
      i_mem_rsp_valid = 1'b0;
      step();

      // Response coinciding with the accept cycle must be ignored
      run_txn(3'b011, 1, 2, 1'b1, $urandom);

      // Reset while waiting on a response from requester 1
      run_txn(3'b001, 0, 0, 1'b0, $urandom);
      grant_phase(3'b010, g);
      issue_phase(1, 1'b0);
      #3;
      i_rst_n = 1'b0;
      #1;
      check_zero("abort");
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      i_mem_rsp_valid = 1'b1;
      rr = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         #1;
         chk("abort_no_rsp", 32'(o_rsp_valid), 0);
         chk("abort_idle", 32'(o_busy), 0);
      end
      i_mem_rsp_valid = 1'b0;
      step();
      run_txn(3'b111, 0, 0, 1'b0, $urandom);

      // Randomized traffic
      for (int i = 0; i < 30; i++) begin
         for (int k = 0; k < N; k++) rand_payload(k);
         run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom);
      end

`ifdef MEM_ARB_TIMEOUT_EN
      // Watchdog: requester 1 read with no downstream response
      wen_a[1] = 1'b0;
      grant_phase(3'b010, g);
      issue_phase(0, 1'b0);
      for (int d = 0; d < TMO; d++) begin
         #1;
         chk("tmo_wait_rsp", 32'(o_rsp_valid), 0);
         chk("tmo_wait_busy", 32'(o_busy), 1);
         step();
      end
      #1;
      chk("tmo_rsp_valid", 32'(o_rsp_valid), 32'(onehot(1)));
      chk("tmo_rsp_err",   32'(o_rsp_err), 1);
      chk("tmo_rsp_rdata", o_rsp_rdata, 0);
      rr = 2;
      i_mem_rsp_valid = 1'b1;
      step();
      #1;
      chk("tmo_late_rsp", 32'(o_rsp_valid), 0);
      i_mem_rsp_valid = 1'b0;
      run_txn(3'b111, 0, 0, 1'b0, $urandom);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
